// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_seq_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_KILL,
    S_HOLD
  } fetch_state_e;

  // Byte distance between sequential instructions.
  localparam int PC_INC = 4;

endpackage : fetch_seq_pkg

// File: rtl/adder.sv
// Plain N-bit adder; the sum wraps modulo 2^N with no carry out.
module adder #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  assign y = a + b;

endmodule : adder

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues req/ack fetches to
// instruction memory, hands instructions to decode over valid/ready and
// applies branch redirects at any time, including mid-access.
// Optional build macro FETCH_SEQ_PERF_EN adds perf_fetched / perf_stall
// counters and their output ports.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int             N        = 64,
  parameter int             INSTR_W  = 32,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCSrc_F,
  input  logic [N-1:0]       PCBranch_F,
  output logic               imem_req_F,
  output logic [N-1:0]       imem_addr_F,
  input  logic               imem_ack_F,
  input  logic [INSTR_W-1:0] imem_rdata_F,
  output logic               instr_valid_D,
  output logic [INSTR_W-1:0] instr_D,
  output logic [N-1:0]       pc_D,
  input  logic               instr_ready_D
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  fetch_state_e       state_q, state_d;
  logic [N-1:0]       pc_q, pc_d;
  logic [N-1:0]       pending_q, pending_d;
  logic [N-1:0]       pc_out_q, pc_out_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               req_q, req_d;
  logic [N-1:0]       pc_inc;

  // Sequential next PC, wrapping at 2^N.
  adder #(.N(N)) u_pc_adder (
    .a (pc_q),
    .b (N'(PC_INC)),
    .y (pc_inc)
  );

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    // NOTE: every signal gets a default hold value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    pc_out_d  = pc_out_q;
    instr_d   = instr_q;
    valid_d   = valid_q;

    case (state_q)
      S_IDLE: begin
        if (PCSrc_F) pc_d = PCBranch_F;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack_F) begin
          if (PCSrc_F) begin
            // Response belongs to the wrong path: drop it, refetch at target.
            pc_d = PCBranch_F;
          end else begin
            instr_d  = imem_rdata_F;
            pc_out_d = pc_q;
            pc_d     = pc_inc;
            valid_d  = 1'b1;
            state_d  = S_HOLD;
          end
        end else if (PCSrc_F) begin
          // Request cannot be withdrawn; remember target until the ack drains it.
          pending_d = PCBranch_F;
          state_d   = S_KILL;
        end
      end
      S_KILL: begin
        if (imem_ack_F) begin
          pc_d    = PCSrc_F ? PCBranch_F : pending_q;
          state_d = S_FETCH;
        end else if (PCSrc_F) begin
          pending_d = PCBranch_F;
        end
      end
      S_HOLD: begin
        if (PCSrc_F) begin
          valid_d = 1'b0;
          pc_d    = PCBranch_F;
          state_d = S_FETCH;
        end else if (instr_ready_D) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_d = (state_d == S_FETCH) || (state_d == S_KILL);
  end

  // FSM state and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      // NOTE: every register here is small control/datapath state, so all of it is reset.
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      pending_q <= '0;
      pc_out_q  <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      pc_out_q  <= pc_out_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      req_q     <= req_d;
    end
  end

  assign imem_req_F    = req_q;
  assign imem_addr_F   = pc_q;
  assign instr_valid_D = valid_q;
  assign instr_D       = instr_q;
  assign pc_D          = pc_out_q;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;

  // Count decode handshakes and memory wait cycles; both wrap at 2^32.
  always_comb begin
    fetched_d = fetched_q + 32'((state_q == S_HOLD) && instr_ready_D);
    stall_d   = stall_q +
                32'(((state_q == S_FETCH) || (state_q == S_KILL)) && !imem_ack_F);
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer. A second instance with
// RESET_PC = 2^64-4 covers PC wrap-around. Outputs are sampled 1 ns after
// each rising edge; inputs change at the same point.
module tb_fetch_sequencer;

  localparam int N       = 64;
  localparam int INSTR_W = 32;
  localparam logic [N-1:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [31:0]  DATA_OFS = 32'h1000_0000;

  logic               clk = 1'b0;
  logic               reset;
  logic               pcsrc;
  logic [N-1:0]       branch;
  logic               ack;
  logic               ready;

  logic               req;
  logic [N-1:0]       addr;
  logic [INSTR_W-1:0] rdata;
  logic               valid;
  logic [INSTR_W-1:0] instr;
  logic [N-1:0]       pcd;

  logic               req1;
  logic [N-1:0]       addr1;
  logic [INSTR_W-1:0] rdata1;
  logic               valid1;
  logic [INSTR_W-1:0] instr1;
  logic [N-1:0]       pcd1;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
  logic [31:0] perf_fetched1, perf_stall1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Memory model: instruction word is derived from its address.
  assign rdata  = addr[31:0] + DATA_OFS;
  assign rdata1 = addr1[31:0] + DATA_OFS;

  fetch_sequencer #(.N(N), .INSTR_W(INSTR_W), .RESET_PC('0)) dut (
    .clk           (clk),
    .reset         (reset),
    .PCSrc_F       (pcsrc),
    .PCBranch_F    (branch),
    .imem_req_F    (req),
    .imem_addr_F   (addr),
    .imem_ack_F    (ack),
    .imem_rdata_F  (rdata),
    .instr_valid_D (valid),
    .instr_D       (instr),
    .pc_D          (pcd),
    .instr_ready_D (ready)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall)
`endif
  );

  fetch_sequencer #(.N(N), .INSTR_W(INSTR_W), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk           (clk),
    .reset         (reset),
    .PCSrc_F       (1'b0),
    .PCBranch_F    ('0),
    .imem_req_F    (req1),
    .imem_addr_F   (addr1),
    .imem_ack_F    (1'b1),
    .imem_rdata_F  (rdata1),
    .instr_valid_D (valid1),
    .instr_D       (instr1),
    .pc_D          (pcd1),
    .instr_ready_D (1'b1)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .perf_fetched  (perf_fetched1),
    .perf_stall    (perf_stall1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   64'(req),   64'd0);
    check({tag, "_valid"}, 64'(valid), 64'd0);
    check({tag, "_instr"}, 64'(instr), 64'd0);
    check({tag, "_pcd"},   pcd,        64'd0);
    check({tag, "_addr"},  addr,       64'd0);
  endtask

  initial begin
    reset = 1'b1; pcsrc = 1'b0; branch = '0; ack = 1'b0; ready = 1'b0;
    tick(); tick();
    check_reset_outputs("rst");
    check("rst_wrap_addr", addr1, WRAP_PC);
    check("rst_wrap_req", 64'(req1), 64'd0);

    // 1: zero-wait memory, decode always ready.
    ack = 1'b1; ready = 1'b1; reset = 1'b0;
    tick();
    check("t1_req0", 64'(req), 64'd1);
    check("t1_addr0", addr, 64'h0);
    check("t1_valid0", 64'(valid), 64'd0);
    check("t5_addr_top", addr1, WRAP_PC);
    tick();
    check("t1_valid1", 64'(valid), 64'd1);
    check("t1_instr1", 64'(instr), 64'h1000_0000);
    check("t1_pcd1", pcd, 64'h0);
    check("t1_req1", 64'(req), 64'd0);
    check("t5_pcd_top", pcd1, WRAP_PC);
    check("t5_valid_top", 64'(valid1), 64'd1);
    tick();
    check("t1_valid2", 64'(valid), 64'd0);
    check("t1_addr2", addr, 64'h4);
    check("t5_addr_wrap", addr1, 64'h0);
    check("t5_req_wrap", 64'(req1), 64'd1);
    tick();
    check("t1_valid3", 64'(valid), 64'd1);
    check("t1_instr3", 64'(instr), 64'h1000_0004);
    check("t1_pcd3", pcd, 64'h4);
    check("t5_pcd_wrap", pcd1, 64'h0);
    tick();
    check("t1_addr4", addr, 64'h8);
    check("t1_req4", 64'(req), 64'd1);

    // 2: ack delayed 3 cycles, redirect to 0x100 on the first wait cycle.
    ack = 1'b0; pcsrc = 1'b1; branch = 64'h100;
    tick();
    pcsrc = 1'b0;
    check("t2_w1_addr", addr, 64'h8);
    check("t2_w1_req", 64'(req), 64'd1);
    check("t2_w1_valid", 64'(valid), 64'd0);
    tick();
    check("t2_w2_addr", addr, 64'h8);
    check("t2_w2_valid", 64'(valid), 64'd0);
    tick();
    check("t2_w3_addr", addr, 64'h8);
    check("t2_w3_valid", 64'(valid), 64'd0);
    ack = 1'b1;
    tick();
    check("t2_redir_addr", addr, 64'h100);
    check("t2_redir_req", 64'(req), 64'd1);
    check("t2_redir_valid", 64'(valid), 64'd0);
`ifdef FETCH_SEQ_PERF_EN
    check("t2_perf_stall", 64'(perf_stall), 64'd3);
    check("t2_perf_fetched", 64'(perf_fetched), 64'd2);
`endif
    tick();
    check("t2_valid", 64'(valid), 64'd1);
    check("t2_pcd", pcd, 64'h100);
    check("t2_instr", 64'(instr), 64'h1000_0100);

    // 4: decode stalls for 5 cycles, then redirect to 0x40 while held.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", 64'(valid), 64'd1);
      check("t4_hold_instr", 64'(instr), 64'h1000_0100);
      check("t4_hold_pcd", pcd, 64'h100);
      check("t4_hold_req", 64'(req), 64'd0);
    end
    pcsrc = 1'b1; branch = 64'h40;
    tick();
    pcsrc = 1'b0;
    check("t4_drop_valid", 64'(valid), 64'd0);
    check("t4_redir_addr", addr, 64'h40);
    check("t4_redir_req", 64'(req), 64'd1);
`ifdef FETCH_SEQ_PERF_EN
    check("t4_perf_fetched", 64'(perf_fetched), 64'd2);
`endif
    tick();
    check("t4_pcd", pcd, 64'h40);

    // 3: two redirects while waiting in S_KILL; latest wins.
    ready = 1'b1; ack = 1'b0;
    tick();
    check("t3_addr_seq", addr, 64'h44);
    pcsrc = 1'b1; branch = 64'h200;
    tick();
    branch = 64'h300;
    tick();
    pcsrc = 1'b0;
    check("t3_kill_addr", addr, 64'h44);
    check("t3_kill_req", 64'(req), 64'd1);
    ack = 1'b1;
    tick();
    check("t3_latest_addr", addr, 64'h300);
    check("t3_latest_valid", 64'(valid), 64'd0);

    // Redirect coinciding with ack in S_KILL takes the new target.
    ack = 1'b0; pcsrc = 1'b1; branch = 64'h500;
    tick();
    ack = 1'b1; branch = 64'h600;
    tick();
    check("kill_ack_redir_addr", addr, 64'h600);
    // Redirect coinciding with ack in S_FETCH drops the data.
    branch = 64'h700;
    tick();
    pcsrc = 1'b0;
    check("fetch_ack_redir_addr", addr, 64'h700);
    check("fetch_ack_redir_valid", 64'(valid), 64'd0);

    // 6: reset during S_KILL, late ack while in reset, then reset in S_HOLD.
    ack = 1'b0; pcsrc = 1'b1; branch = 64'h800;
    tick();
    pcsrc = 1'b0;
    check("t6_kill_addr", addr, 64'h700);
    reset = 1'b1;
    tick();
    check_reset_outputs("t6_kill_rst");
`ifdef FETCH_SEQ_PERF_EN
    check("t6_perf_stall_rst", 64'(perf_stall), 64'd0);
    check("t6_perf_fetched_rst", 64'(perf_fetched), 64'd0);
`endif
    ack = 1'b1;
    tick();
    check("t6_late_ack_valid", 64'(valid), 64'd0);
    reset = 1'b0;
    tick();
    check("t6_first_req", 64'(req), 64'd1);
    check("t6_first_addr", addr, 64'h0);
    tick();
    check("t6_hold_valid", 64'(valid), 64'd1);
    check("t6_hold_pcd", pcd, 64'h0);
    ready = 1'b0;
    reset = 1'b1;
    tick();
    check_reset_outputs("t6_hold_rst");
    reset = 1'b0;
    tick();
    check("t6_after_req", 64'(req), 64'd1);
    check("t6_after_addr", addr, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench time limit reached");
  end

endmodule : tb_fetch_sequencer
